logo_motion_ctrl: RTL and testbench

LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

---
 rtl/logo_pkg.sv | 33 +++
 rtl/logo_motion_ctrl_btn_debounce.sv | 55 +++++
 rtl/logo_motion_ctrl.sv | 152 +++++++++++++++
 tb/tb_logo_motion_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/logo_pkg.sv
// Shared constants, state encoding and a saturation helper for the bouncing-logo controller.
package logo_pkg;

    localparam int LOGO_W = 120;
    localparam int LOGO_H = 160;
    localparam int H_ACT  = 640;
    localparam int V_ACT  = 480;
    localparam int HOME_X = 260;
    localparam int HOME_Y = 160;
    localparam int X_MAX  = H_ACT - LOGO_W;
    localparam int Y_MAX  = V_ACT - LOGO_H;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        HOME   = 2'd2
    } mode_e;

    // Signed input so a step below zero is caught instead of wrapping to a large value.
    function automatic logic [9:0] clampPos(input logic signed [10:0] v,
                                            input logic signed [10:0] lim);
        logic [9:0] r;
        if (v < 11'sd0) begin
            r = 10'd0;
        end else if (v > lim) begin
            r = lim[9:0];
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/logo_motion_ctrl_btn_debounce.sv
// One push button: 2-FF synchronizer, frame-tick counted debounce and debounced rising edge.
module btn_debounce #(
    parameter int DEB_TICKS = 2
) (
    input  logic pclk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic pressed_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEB_TICKS);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // The tick that completes the count already reports the press, so it moves in that frame.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = press_q;
        if (tick_i) begin
            if (sync_q) begin
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
            press_d = (cnt_d == CNT_FULL);
        end
    end

    assign pressed_o = press_d;
    assign rise_o    = press_d & ~press_q;

endmodule

// File: rtl/logo_motion_ctrl.sv
// Moves a logo once per frame: manual button steps, diagonal bounce, or a jump to home.
module logo_motion_ctrl #(
    parameter int LOGO_W    = logo_pkg::LOGO_W,
    parameter int LOGO_H    = logo_pkg::LOGO_H,
    parameter int H_ACT     = logo_pkg::H_ACT,
    parameter int V_ACT     = logo_pkg::V_ACT,
    parameter int HOME_X    = logo_pkg::HOME_X,
    parameter int HOME_Y    = logo_pkg::HOME_Y,
    parameter int DEB_TICKS = 2
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_mid,
    input  logic       auto_en,
    output logic [9:0] logo_x,
    output logic [9:0] logo_y,
    output logic       frame_tick,
    output logic [1:0] mode
);
    import logo_pkg::*;

    localparam logic signed [10:0] XLIM = 11'(H_ACT - LOGO_W);
    localparam logic signed [10:0] YLIM = 11'(V_ACT - LOGO_H);
    localparam logic [9:0]         HX   = 10'(HOME_X);
    localparam logic [9:0]         HY   = 10'(HOME_Y);

    logic vsMeta_q, vsSync_q, vsPrev_q, tick_q;
    logic autoMeta_q, autoSync_q;
    logic upP, downP, leftP, rightP, midP;
    logic upR, downR, leftR, rightR, midR;
    logic [4:0] unusedDeb;

    mode_e      state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       dxNeg_q, dxNeg_d, dyNeg_q, dyNeg_d;
    logic signed [10:0] xCur, yCur, xAuto, yAuto;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) uDebUp (
        .pclk(pclk), .rst(rst), .tick_i(tick_q), .btn_i(btn_up), .pressed_o(upP), .rise_o(upR));
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) uDebDown (
        .pclk(pclk), .rst(rst), .tick_i(tick_q), .btn_i(btn_down), .pressed_o(downP), .rise_o(downR));
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) uDebLeft (
        .pclk(pclk), .rst(rst), .tick_i(tick_q), .btn_i(btn_left), .pressed_o(leftP), .rise_o(leftR));
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) uDebRight (
        .pclk(pclk), .rst(rst), .tick_i(tick_q), .btn_i(btn_right), .pressed_o(rightP), .rise_o(rightR));
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) uDebMid (
        .pclk(pclk), .rst(rst), .tick_i(tick_q), .btn_i(btn_mid), .pressed_o(midP), .rise_o(midR));

    assign unusedDeb = {upR, downR, leftR, rightR, midP};

    // frame_tick lands 3 cycles after raw vsync rises: two sync stages plus the edge register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsMeta_q   <= 1'b0;
            vsSync_q   <= 1'b0;
            vsPrev_q   <= 1'b0;
            tick_q     <= 1'b0;
            autoMeta_q <= 1'b0;
            autoSync_q <= 1'b0;
        end else begin
            vsMeta_q   <= vsync;
            vsSync_q   <= vsMeta_q;
            vsPrev_q   <= vsSync_q;
            tick_q     <= vsSync_q & ~vsPrev_q;
            autoMeta_q <= auto_en;
            autoSync_q <= autoMeta_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= MANUAL;
            x_q     <= HX;
            y_q     <= HY;
            dxNeg_q <= 1'b0;
            dyNeg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dxNeg_q <= dxNeg_d;
            dyNeg_q <= dyNeg_d;
        end
    end

    assign xCur  = $signed({1'b0, x_q});
    assign yCur  = $signed({1'b0, y_q});
    assign xAuto = xCur + (dxNeg_q ? -11'sd1 : 11'sd1);
    assign yAuto = yCur + (dyNeg_q ? -11'sd1 : 11'sd1);

    // Leaving HOME, or switching mode, applies the newly selected mode's move in that same tick.
    // Bounce reverses on reaching an edge, so a corner visit shows the bound for exactly one frame.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dxNeg_d = dxNeg_q;
        dyNeg_d = dyNeg_q;
        if (tick_q) begin
            if (midR) begin
                state_d = HOME;
                x_d     = HX;
                y_d     = HY;
                dxNeg_d = 1'b0;
                dyNeg_d = 1'b0;
            end else if (autoSync_q) begin
                state_d = AUTO;
                if (xAuto <= 11'sd0) begin
                    x_d     = 10'd0;
                    dxNeg_d = 1'b0;
                end else if (xAuto >= XLIM) begin
                    x_d     = XLIM[9:0];
                    dxNeg_d = 1'b1;
                end else begin
                    x_d = xAuto[9:0];
                end
                if (yAuto <= 11'sd0) begin
                    y_d     = 10'd0;
                    dyNeg_d = 1'b0;
                end else if (yAuto >= YLIM) begin
                    y_d     = YLIM[9:0];
                    dyNeg_d = 1'b1;
                end else begin
                    y_d = yAuto[9:0];
                end
            end else begin
                state_d = MANUAL;
                if (rightP && !leftP) begin
                    x_d = clampPos(xCur + 11'sd1, XLIM);
                end else if (leftP && !rightP) begin
                    x_d = clampPos(xCur - 11'sd1, XLIM);
                end
                if (downP && !upP) begin
                    y_d = clampPos(yCur + 11'sd1, YLIM);
                end else if (upP && !downP) begin
                    y_d = clampPos(yCur - 11'sd1, YLIM);
                end
            end
        end
    end

    assign logo_x     = x_q;
    assign logo_y     = y_q;
    assign frame_tick = tick_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Directed bench for logo_motion_ctrl: manual moves, saturation, bounce, home and reset.
module tb_logo_motion_ctrl;

    logic       pclk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       btn_up, btn_down, btn_left, btn_right, btn_mid;
    logic       auto_en;
    logic [9:0] logo_x, logo_y;
    logic       frame_tick;
    logic [1:0] mode;

    int assertCount = 0;
    int failCount   = 0;

    logo_motion_ctrl dut (
        .pclk(pclk), .rst(rst), .vsync(vsync),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_mid(btn_mid), .auto_en(auto_en),
        .logo_x(logo_x), .logo_y(logo_y), .frame_tick(frame_tick), .mode(mode)
    );

    always #5 pclk = ~pclk;

    // Runs whole frames (vsync low, then high long enough for the tick and the update).
    task automatic applyStimulus(input int nFrames);
        int ticks;
        ticks = 0;
        for (int f = 0; f < nFrames; f++) begin
            @(negedge pclk);
            vsync = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge pclk);
                if (frame_tick) ticks++;
            end
            vsync = 1'b1;
            for (int c = 0; c < 8; c++) begin
                @(negedge pclk);
                if (frame_tick) ticks++;
            end
        end
        assertCount++;
        assert (ticks === nFrames) else begin
            failCount++;
            $error("[TB] FAIL tickCount: observed %0d expected %0d", ticks, nFrames);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int ex, input int ey, input int em);
        assertCount++;
        assert (logo_x === 10'(ex)) else begin
            failCount++;
            $error("[TB] FAIL %s.x: observed %0d expected %0d", tag, logo_x, ex);
        end
        assertCount++;
        assert (logo_y === 10'(ey)) else begin
            failCount++;
            $error("[TB] FAIL %s.y: observed %0d expected %0d", tag, logo_y, ey);
        end
        assertCount++;
        assert (mode === 2'(em)) else begin
            failCount++;
            $error("[TB] FAIL %s.mode: observed %0d expected %0d", tag, mode, em);
        end
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; auto_en = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_mid = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        checkOutput("reset", 260, 160, 0);
        checkBit("resetTick", frame_tick, 1'b0);
        rst = 1'b0;

        // First tick only qualifies the press: 4 moves in 5 frames.
        btn_right = 1'b1;
        applyStimulus(5);
        checkOutput("right5", 264, 160, 0);
        btn_right = 1'b0;
        applyStimulus(1);
        checkOutput("release", 264, 160, 0);

        btn_left = 1'b1;
        applyStimulus(1);
        btn_left = 1'b0;
        applyStimulus(1);
        checkOutput("glitch", 264, 160, 0);

        btn_up = 1'b1; btn_down = 1'b1;
        applyStimulus(4);
        checkOutput("upDown", 264, 160, 0);
        btn_up = 1'b0; btn_down = 1'b0;
        applyStimulus(1);

        // Diagonal walk to 519/319.
        btn_right = 1'b1; btn_down = 1'b1;
        applyStimulus(160);
        checkOutput("diag", 423, 319, 0);
        btn_down = 1'b0;
        applyStimulus(96);
        checkOutput("nearCorner", 519, 319, 0);
        btn_right = 1'b0;

        // Corner bounce in AUTO.
        auto_en = 1'b1;
        applyStimulus(1);
        checkOutput("corner", 520, 320, 1);
        applyStimulus(1);
        checkOutput("bounce1", 519, 319, 1);
        applyStimulus(1);
        checkOutput("bounce2", 518, 318, 1);
        applyStimulus(117);
        checkOutput("autoRun", 401, 201, 1);

        // Mid held: qualify, HOME, then AUTO resumes with +1 steps and no repeat.
        btn_mid = 1'b1;
        applyStimulus(1);
        checkOutput("midQual", 400, 200, 1);
        applyStimulus(1);
        checkOutput("home", 260, 160, 2);
        applyStimulus(1);
        checkOutput("afterHome", 261, 161, 1);
        applyStimulus(1);
        checkOutput("midHeld", 262, 162, 1);
        btn_mid = 1'b0; auto_en = 1'b0;
        applyStimulus(1);
        checkOutput("toManual", 262, 162, 0);

        // Saturation at X max and Y zero.
        btn_right = 1'b1; btn_up = 1'b1;
        applyStimulus(257);
        checkOutput("x518y0", 518, 0, 0);
        applyStimulus(10);
        checkOutput("satMax", 520, 0, 0);
        btn_right = 1'b0; btn_up = 1'b0;

        auto_en = 1'b1;
        applyStimulus(1);
        checkOutput("autoEdge", 520, 1, 1);
        applyStimulus(1);
        checkOutput("autoBack", 519, 2, 1);

        // frame_tick exactly 3 cycles after the raw vsync edge, for one cycle.
        @(negedge pclk);
        vsync = 1'b0;
        repeat (4) @(negedge pclk);
        vsync = 1'b1;
        @(posedge pclk); #1;
        checkBit("tickP1", frame_tick, 1'b0);
        @(posedge pclk); #1;
        checkBit("tickP2", frame_tick, 1'b0);
        @(posedge pclk); #1;
        checkBit("tickP3", frame_tick, 1'b1);
        @(posedge pclk); #1;
        checkBit("tickP4", frame_tick, 1'b0);
        checkOutput("tickMove", 518, 3, 1);

        // Mid-frame reset in AUTO.
        @(negedge pclk);
        rst = 1'b1; vsync = 1'b0;
        @(posedge pclk); #1;
        checkOutput("midReset", 260, 160, 0);
        checkBit("midResetTick", frame_tick, 1'b0);
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        repeat (10) @(negedge pclk);
        checkOutput("noMoveAfterRst", 260, 160, 0);
        applyStimulus(1);
        checkOutput("autoAfterRst", 261, 161, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
